// File: rtl/mem_access_stage.sv
// MEM stage: data-memory req/ack handshake with timeout, and the registered MEM/WB outputs.
// state | meaning: IDLE pass-through or launch access | REQ request held awaiting ack | DONE retire access or error
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] aluc_i,
    input  logic [31:0] rD2_i,
    input  logic [31:0] ext_i,
    input  logic [31:0] pc4_i,
    input  logic [4:0]  wR_i,
    input  logic [1:0]  rf_wsel_i,
    input  logic        rf_we_i,
    input  logic        ram_we_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        stall_o,
    output logic [31:0] wD_o,
    output logic [4:0]  wR_o,
    output logic        rf_we_o,
    output logic        err_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_rdata;
    logic             r_err_flag;

    logic             w_access;
    logic             w_misaligned;
    logic [31:0]      w_wb_data;

    assign w_access     = ram_we_i | (rf_wsel_i == 2'b01);
    assign w_misaligned = w_access & (aluc_i[1:0] != 2'b00);
    assign stall_o      = (r_state == S_REQ) | ((r_state == S_IDLE) & w_access);

    always_comb begin
        w_wb_data = aluc_i;
        case (rf_wsel_i)
            2'b00:   w_wb_data = aluc_i;
            2'b01:   w_wb_data = r_rdata;
            2'b10:   w_wb_data = pc4_i;
            default: w_wb_data = ext_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_err_flag  <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            wD_o        <= '0;
            wR_o        <= '0;
            rf_we_o     <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        wD_o    <= '0;
                        wR_o    <= '0;
                        rf_we_o <= 1'b0;
                        if (w_misaligned) begin
                            r_err_flag <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_err_flag  <= 1'b0;
                            bus_addr_o  <= aluc_i;
                            bus_wdata_o <= rD2_i;
                            bus_we_o    <= ram_we_i;
                            bus_req_o   <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= S_REQ;
                        end
                    end else begin
                        wD_o    <= w_wb_data;
                        wR_o    <= wR_i;
                        rf_we_o <= rf_we_i;
                    end
                end
                S_REQ: begin
                    wD_o    <= '0;
                    wR_o    <= '0;
                    rf_we_o <= 1'b0;
                    // ack takes priority over the timeout on the same edge
                    if (bus_ack_i) begin
                        bus_req_o <= 1'b0;
                        bus_we_o  <= 1'b0;
                        r_rdata   <= bus_rdata_i;
                        r_state   <= S_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        bus_req_o  <= 1'b0;
                        bus_we_o   <= 1'b0;
                        r_err_flag <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    wR_o <= wR_i;
                    if (r_err_flag) begin
                        wD_o    <= '0;
                        rf_we_o <= 1'b0;
                        err_o   <= 1'b1;
                    end else begin
                        wD_o    <= w_wb_data;
                        rf_we_o <= rf_we_i;
                    end
                    r_err_flag <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: drives on negedge, samples on the following negedge.
module tb_mem_access_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] aluc_i, rD2_i, ext_i, pc4_i, bus_rdata_i;
    logic [4:0]  wR_i;
    logic [1:0]  rf_wsel_i;
    logic        rf_we_i, ram_we_i, bus_ack_i;
    logic        bus_req_o, bus_we_o, stall_o, rf_we_o, err_o;
    logic [31:0] bus_addr_o, bus_wdata_o, wD_o;
    logic [4:0]  wR_o;

    int n_pass  = 0;
    int n_total = 0;

    mem_access_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .aluc_i(aluc_i), .rD2_i(rD2_i), .ext_i(ext_i), .pc4_i(pc4_i),
        .wR_i(wR_i), .rf_wsel_i(rf_wsel_i), .rf_we_i(rf_we_i), .ram_we_i(ram_we_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
        .stall_o(stall_o), .wD_o(wD_o), .wR_o(wR_o), .rf_we_o(rf_we_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_nop();
        aluc_i = 32'h0; rD2_i = 32'h0; rf_wsel_i = 2'b00;
        rf_we_i = 1'b0; ram_we_i = 1'b0; wR_i = 5'd0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        ext_i = 32'h0; pc4_i = 32'h0;
        set_nop();
        repeat (2) @(negedge clk_i);
        n_total++;
        if ({bus_req_o, bus_we_o, rf_we_o, err_o} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b want 0000", {bus_req_o, bus_we_o, rf_we_o, err_o});
        else n_pass++;
        n_total++;
        if ({bus_addr_o, bus_wdata_o, wD_o, wR_o} !== '0)
            $display("FAIL reset_data: addr=%h wdata=%h wD=%h wR=%0d want all 0",
                     bus_addr_o, bus_wdata_o, wD_o, wR_o);
        else n_pass++;
        rst_i = 1'b0;
    endtask

    task automatic test_alu_op();
        aluc_i = 32'h1234; rf_wsel_i = 2'b00; wR_i = 5'd5; rf_we_i = 1'b1;
        pc4_i = 32'h0000_2004; ext_i = 32'hFFFF_FFF0;
        #1;
        n_total++;
        if (stall_o !== 1'b0) $display("FAIL alu_stall: got %b want 0", stall_o);
        else n_pass++;
        @(negedge clk_i);
        n_total++;
        if ({wD_o, wR_o, rf_we_o, err_o} !== {32'h1234, 5'd5, 1'b1, 1'b0})
            $display("FAIL alu_wb: wD=%h wR=%0d we=%b err=%b want 1234/5/1/0", wD_o, wR_o, rf_we_o, err_o);
        else n_pass++;
        rf_wsel_i = 2'b10; wR_i = 5'd31;
        @(negedge clk_i);
        n_total++;
        if ({wD_o, wR_o} !== {32'h0000_2004, 5'd31})
            $display("FAIL pc4_wb: wD=%h wR=%0d want 00002004/31", wD_o, wR_o);
        else n_pass++;
        rf_wsel_i = 2'b11; rf_we_i = 1'b0;
        @(negedge clk_i);
        n_total++;
        if ({wD_o, rf_we_o} !== {32'hFFFF_FFF0, 1'b0})
            $display("FAIL ext_wb: wD=%h we=%b want fffffff0/0", wD_o, rf_we_o);
        else n_pass++;
        set_nop();
    endtask

    task automatic test_load_fast();
        aluc_i = 32'h100; rf_wsel_i = 2'b01; wR_i = 5'd7; rf_we_i = 1'b1;
        bus_rdata_i = 32'hDEAD_BEEF;
        #1;
        n_total++;
        if ({stall_o, bus_req_o} !== 2'b10) $display("FAIL load_idle: stall/req=%b want 10", {stall_o, bus_req_o});
        else n_pass++;
        @(negedge clk_i);
        n_total++;
        if ({bus_req_o, bus_we_o, stall_o, bus_addr_o, rf_we_o} !== {1'b1, 1'b0, 1'b1, 32'h100, 1'b0})
            $display("FAIL load_req: req=%b we=%b stall=%b addr=%h rfwe=%b want 1/0/1/100/0",
                     bus_req_o, bus_we_o, stall_o, bus_addr_o, rf_we_o);
        else n_pass++;
        bus_ack_i = 1'b1;
        @(negedge clk_i);
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        n_total++;
        if ({bus_req_o, stall_o} !== 2'b00) $display("FAIL load_done: req/stall=%b want 00", {bus_req_o, stall_o});
        else n_pass++;
        @(negedge clk_i);
        n_total++;
        if ({wD_o, wR_o, rf_we_o, err_o} !== {32'hDEAD_BEEF, 5'd7, 1'b1, 1'b0})
            $display("FAIL load_wb: wD=%h wR=%0d we=%b err=%b want deadbeef/7/1/0", wD_o, wR_o, rf_we_o, err_o);
        else n_pass++;
        set_nop();
    endtask

    task automatic test_store_wait();
        int n_stall = 0;
        int n_bad = 0;
        aluc_i = 32'h40; ram_we_i = 1'b1; rD2_i = 32'hA5A5_A5A5; rf_we_i = 1'b0;
        #1;
        if (stall_o) n_stall++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (stall_o) n_stall++;
            if ({bus_req_o, bus_we_o, bus_wdata_o, bus_addr_o} !== {1'b1, 1'b1, 32'hA5A5_A5A5, 32'h40}) n_bad++;
            if (i == 3) bus_ack_i = 1'b1;
        end
        n_total++;
        if (n_bad !== 0) $display("FAIL store_bus_hold: %0d bad cycles want 0", n_bad);
        else n_pass++;
        @(negedge clk_i);
        bus_ack_i = 1'b0;
        if (stall_o) n_stall++;
        n_total++;
        if (n_stall !== 5) $display("FAIL store_stall_len: got %0d want 5", n_stall);
        else n_pass++;
        @(negedge clk_i);
        n_total++;
        if ({rf_we_o, err_o, bus_req_o} !== 3'b000)
            $display("FAIL store_wb: we/err/req=%b want 000", {rf_we_o, err_o, bus_req_o});
        else n_pass++;
        set_nop();
    endtask

    task automatic test_store_rfwe();
        aluc_i = 32'h88; ram_we_i = 1'b1; rD2_i = 32'h1; rf_we_i = 1'b1; wR_i = 5'd9;
        @(negedge clk_i);
        bus_ack_i = 1'b1;
        @(negedge clk_i);
        bus_ack_i = 1'b0;
        @(negedge clk_i);
        n_total++;
        if ({wD_o, wR_o, rf_we_o} !== {32'h88, 5'd9, 1'b1})
            $display("FAIL store_rfwe: wD=%h wR=%0d we=%b want 88/9/1", wD_o, wR_o, rf_we_o);
        else n_pass++;
        set_nop();
    endtask

    task automatic test_timeout();
        int n_req = 0;
        aluc_i = 32'h200; rf_wsel_i = 2'b01; rf_we_i = 1'b1; wR_i = 5'd4;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (bus_req_o) n_req++;
            else break;
        end
        n_total++;
        if (n_req !== 16) $display("FAIL timeout_req_len: got %0d want 16", n_req);
        else n_pass++;
        n_total++;
        if ({err_o, stall_o} !== 2'b00) $display("FAIL timeout_done: err/stall=%b want 00", {err_o, stall_o});
        else n_pass++;
        bus_ack_i = 1'b1; bus_rdata_i = 32'h7777_7777;
        @(negedge clk_i);
        n_total++;
        if ({err_o, rf_we_o, wD_o} !== {1'b1, 1'b0, 32'h0})
            $display("FAIL timeout_err: err=%b we=%b wD=%h want 1/0/0", err_o, rf_we_o, wD_o);
        else n_pass++;
        set_nop();
        @(negedge clk_i);
        bus_ack_i = 1'b0;
        n_total++;
        if ({err_o, bus_req_o} !== 2'b00) $display("FAIL timeout_after: err/req=%b want 00", {err_o, bus_req_o});
        else n_pass++;
    endtask

    task automatic test_ack_at_limit();
        aluc_i = 32'h300; rf_wsel_i = 2'b01; rf_we_i = 1'b1; wR_i = 5'd12;
        @(negedge clk_i);
        repeat (15) @(negedge clk_i);
        n_total++;
        if (bus_req_o !== 1'b1) $display("FAIL limit_req: got %b want 1", bus_req_o);
        else n_pass++;
        bus_ack_i = 1'b1; bus_rdata_i = 32'h1234_5678;
        @(negedge clk_i);
        bus_ack_i = 1'b0;
        @(negedge clk_i);
        n_total++;
        if ({err_o, rf_we_o, wD_o} !== {1'b0, 1'b1, 32'h1234_5678})
            $display("FAIL limit_ack_wins: err=%b we=%b wD=%h want 0/1/12345678", err_o, rf_we_o, wD_o);
        else n_pass++;
        set_nop();
    endtask

    task automatic test_misaligned();
        aluc_i = 32'h102; rf_wsel_i = 2'b01; rf_we_i = 1'b1; wR_i = 5'd3;
        #1;
        n_total++;
        if (stall_o !== 1'b1) $display("FAIL mis_stall: got %b want 1", stall_o);
        else n_pass++;
        @(negedge clk_i);
        n_total++;
        if ({bus_req_o, stall_o, err_o} !== 3'b000)
            $display("FAIL mis_done: req/stall/err=%b want 000", {bus_req_o, stall_o, err_o});
        else n_pass++;
        @(negedge clk_i);
        n_total++;
        if ({err_o, rf_we_o, bus_req_o} !== 3'b100)
            $display("FAIL mis_err: err/we/req=%b want 100", {err_o, rf_we_o, bus_req_o});
        else n_pass++;
        set_nop();
        @(negedge clk_i);
        n_total++;
        if (err_o !== 1'b0) $display("FAIL mis_err_pulse: got %b want 0", err_o);
        else n_pass++;
    endtask

    task automatic test_reset_mid_req();
        aluc_i = 32'h300; rf_wsel_i = 2'b01; rf_we_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        n_total++;
        if ({bus_req_o, bus_we_o, rf_we_o, err_o, bus_addr_o, wD_o, wR_o} !== '0)
            $display("FAIL rst_mid_req: req=%b addr=%h wD=%h we=%b want all 0", bus_req_o, bus_addr_o, wD_o, rf_we_o);
        else n_pass++;
        aluc_i = 32'h55; rf_wsel_i = 2'b00; wR_i = 5'd3; rf_we_i = 1'b1; bus_ack_i = 1'b1;
        #1;
        n_total++;
        if (stall_o !== 1'b0) $display("FAIL rst_alu_stall: got %b want 0", stall_o);
        else n_pass++;
        @(negedge clk_i);
        bus_ack_i = 1'b0;
        n_total++;
        if ({wD_o, wR_o, rf_we_o, bus_req_o} !== {32'h55, 5'd3, 1'b1, 1'b0})
            $display("FAIL rst_alu_wb: wD=%h wR=%0d we=%b req=%b want 55/3/1/0", wD_o, wR_o, rf_we_o, bus_req_o);
        else n_pass++;
        set_nop();
    endtask

    task automatic test_back_to_back();
        logic [5:0] stalls = '0;
        aluc_i = 32'h10; rf_wsel_i = 2'b01; rf_we_i = 1'b1; wR_i = 5'd1; bus_rdata_i = 32'h111;
        #1; stalls[5] = stall_o;
        @(negedge clk_i); stalls[4] = stall_o; bus_ack_i = 1'b1;
        @(negedge clk_i); stalls[3] = stall_o; bus_ack_i = 1'b0;
        @(negedge clk_i);
        n_total++;
        if ({wD_o, wR_o} !== {32'h111, 5'd1}) $display("FAIL b2b_first: wD=%h wR=%0d want 111/1", wD_o, wR_o);
        else n_pass++;
        aluc_i = 32'h20; wR_i = 5'd2; bus_rdata_i = 32'h222;
        #1; stalls[2] = stall_o;
        @(negedge clk_i); stalls[1] = stall_o; bus_ack_i = 1'b1;
        @(negedge clk_i); stalls[0] = stall_o; bus_ack_i = 1'b0;
        @(negedge clk_i);
        n_total++;
        if (stalls !== 6'b110110) $display("FAIL b2b_stall: got %b want 110110", stalls);
        else n_pass++;
        n_total++;
        if ({wD_o, wR_o, rf_we_o} !== {32'h222, 5'd2, 1'b1})
            $display("FAIL b2b_second: wD=%h wR=%0d we=%b want 222/2/1", wD_o, wR_o, rf_we_o);
        else n_pass++;
        set_nop();
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load_fast();
        test_store_wait();
        test_store_rfwe();
        test_timeout();
        test_ack_at_limit();
        test_misaligned();
        test_reset_mid_req();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
